// File: rtl/spi_slave_responder.sv
// SPI mode-0 target: oversamples the SPI pins on clk and exposes valid/ready byte streams.
// Define SPI_RX_WORD_EN to build the 32-bit word packer behind word_data/word_valid.
module spi_slave_responder #(
    parameter logic [7:0] FILL_BYTE   = 8'hFF,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        spi_sck,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        tx_underrun,
    output logic        frame_active,
    output logic [7:0]  byte_count,
    output logic        frame_abort,
    output logic [31:0] word_data,
    output logic        word_valid
);
    typedef enum logic {IDLE, ACTIVE} state_t;

    // One {cs_n, sck, mosi} group per stage. Everything resets to zero so a CS that is
    // already low at reset release never looks like a fresh falling edge.
    logic [3*SYNC_STAGES-1:0] sync_reg;
    logic                     cs_d_reg;
    logic                     sck_d_reg;
    logic                     cs_s;
    logic                     sck_s;
    logic                     mosi_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg  <= '0;
            cs_d_reg  <= 1'b0;
            sck_d_reg <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[3*SYNC_STAGES-4:0], spi_cs_n, spi_sck, spi_mosi};
            cs_d_reg  <= cs_s;
            sck_d_reg <= sck_s;
        end
    end

    assign {cs_s, sck_s, mosi_s} = sync_reg[3*SYNC_STAGES-1 -: 3];

    state_t     state_reg;
    logic [6:0] rx_shift_reg;
    logic [2:0] bit_cnt_reg;
    logic [7:0] tx_shift_reg;
    logic       miso_reg;
    logic [7:0] rx_data_reg;
    logic       rx_valid_reg;
    logic       underrun_reg;
    logic [7:0] byte_count_reg;
    logic       abort_reg;
    logic [7:0] hold_reg;
    logic       hold_full_reg;

    logic       active;
    logic       cs_fall;
    logic       cs_rise;
    logic       sck_rise;
    logic       sck_fall;
    logic       frame_start;
    logic       byte_done;
    logic       tx_load;
    logic [7:0] tx_src;
    logic [7:0] rx_byte;

    // A CS rise outranks any SCK edge seen in the same cycle.
    assign active      = (state_reg == ACTIVE);
    assign cs_fall     = cs_d_reg & ~cs_s;
    assign cs_rise     = ~cs_d_reg & cs_s;
    assign sck_rise    = active & ~cs_rise & ~sck_d_reg & sck_s;
    assign sck_fall    = active & ~cs_rise & sck_d_reg & ~sck_s;
    assign frame_start = ~active & cs_fall;
    assign byte_done   = sck_rise & (bit_cnt_reg == 3'd7);
    assign tx_load     = frame_start | byte_done;
    assign tx_src      = hold_full_reg ? hold_reg : FILL_BYTE;
    assign rx_byte     = {rx_shift_reg, mosi_s};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            rx_shift_reg   <= '0;
            bit_cnt_reg    <= '0;
            tx_shift_reg   <= '0;
            miso_reg       <= 1'b1;
            rx_data_reg    <= '0;
            rx_valid_reg   <= 1'b0;
            underrun_reg   <= 1'b0;
            byte_count_reg <= '0;
            abort_reg      <= 1'b0;
            hold_reg       <= '0;
            hold_full_reg  <= 1'b0;
        end else begin
            rx_valid_reg <= 1'b0;
            underrun_reg <= 1'b0;
            abort_reg    <= 1'b0;

            // A load sees the pre-cycle holding register; a same-cycle write lands afterwards.
            if (tx_load && hold_full_reg) begin
                hold_full_reg <= 1'b0;
            end else if (tx_valid && !hold_full_reg) begin
                hold_reg      <= tx_data;
                hold_full_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (cs_fall) begin
                        state_reg      <= ACTIVE;
                        miso_reg       <= tx_src[7];
                        tx_shift_reg   <= {tx_src[6:0], 1'b0};
                        underrun_reg   <= ~hold_full_reg;
                        bit_cnt_reg    <= '0;
                        byte_count_reg <= '0;
                        rx_shift_reg   <= '0;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state_reg    <= IDLE;
                        miso_reg     <= 1'b1;
                        abort_reg    <= (bit_cnt_reg != 3'd0);
                        bit_cnt_reg  <= '0;
                        rx_shift_reg <= '0;
                    end else begin
                        if (sck_rise) begin
                            rx_shift_reg <= rx_byte[6:0];
                            bit_cnt_reg  <= bit_cnt_reg + 3'd1;
                            if (bit_cnt_reg == 3'd7) begin
                                rx_data_reg  <= rx_byte;
                                rx_valid_reg <= 1'b1;
                                if (byte_count_reg != 8'hFF)
                                    byte_count_reg <= byte_count_reg + 8'd1;
                                tx_shift_reg <= tx_src;
                                underrun_reg <= ~hold_full_reg;
                            end
                        end
                        if (sck_fall) begin
                            miso_reg     <= tx_shift_reg[7];
                            tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign spi_miso     = miso_reg;
    assign spi_miso_oe  = active;
    assign frame_active = active;
    assign rx_data      = rx_data_reg;
    assign rx_valid     = rx_valid_reg;
    assign tx_ready     = ~hold_full_reg;
    assign tx_underrun  = underrun_reg;
    assign byte_count   = byte_count_reg;
    assign frame_abort  = abort_reg;

`ifdef SPI_RX_WORD_EN
    logic [23:0] word_shift_reg;
    logic [1:0]  word_cnt_reg;
    logic [31:0] word_data_reg;
    logic        word_valid_reg;

    // First byte of each group of four ends up in word_data[31:24].
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_shift_reg <= '0;
            word_cnt_reg   <= '0;
            word_data_reg  <= '0;
            word_valid_reg <= 1'b0;
        end else begin
            word_valid_reg <= 1'b0;
            if (frame_start) begin
                word_shift_reg <= '0;
                word_cnt_reg   <= '0;
            end else if (byte_done) begin
                word_shift_reg <= {word_shift_reg[15:0], rx_byte};
                word_cnt_reg   <= word_cnt_reg + 2'd1;
                if (word_cnt_reg == 2'd3) begin
                    word_data_reg  <= {word_shift_reg, rx_byte};
                    word_valid_reg <= 1'b1;
                end
            end
        end
    end

    assign word_data  = word_data_reg;
    assign word_valid = word_valid_reg;
`else
    assign word_data  = '0;
    assign word_valid = 1'b0;
`endif

endmodule
